// File: rtl/pool2d_stream.sv
// Streaming KxK non-overlapping pooling (max or sum/average) over a raster pixel stream.
// Optional POOL_AVG_EN: sum mode emits the truncating window average instead of the wrapping sum.
module pool2d_stream #(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int K      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              mode,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready
);

   localparam int LOG2K = (K == 4) ? 2 : 1;
   localparam int ACC_W = DATA_W + 2 * LOG2K;
   localparam int NBUF  = IMG_W / K;
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int IDX_W = (NBUF > 1) ? $clog2(NBUF) : 1;

   generate
      if (!(K == 2 || K == 4)) begin : g_bad_k
         $error("pool2d_stream: K must be 2 or 4");
      end
      if ((IMG_W % K) != 0 || (IMG_H % K) != 0) begin : g_bad_dim
         $error("pool2d_stream: IMG_W and IMG_H must be multiples of K");
      end
   endgenerate

   function automatic logic [ACC_W-1:0] combine(input logic m, input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
      return m ? ((a > b) ? a : b) : a + b;
   endfunction

   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic              mode_q;
   logic [ACC_W-1:0]  h_acc;
   logic [ACC_W-1:0]  row_buf [NBUF];

   logic              accept, drain, first_pix, mode_eff, grp_end, win_end, col_end, row_end;
   logic [LOG2K-1:0]  grp_pos, row_pos;
   logic [IDX_W-1:0]  idx;
   logic [ACC_W-1:0]  px, h_next, buf_rd, win_res;
   logic [DATA_W-1:0] res_fmt;

   // Handshake: a beat moves on either side only in a cycle where valid && ready;
   // the output register is one deep, so input stalls exactly while a result waits.
   assign in_ready = ce && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready;

   always_comb begin
      first_pix = (col == '0) && (row == '0);
      mode_eff  = first_pix ? mode : mode_q;
      grp_pos   = col[LOG2K-1:0];
      row_pos   = row[LOG2K-1:0];
      grp_end   = (grp_pos == LOG2K'(K - 1));
      win_end   = grp_end && (row_pos == LOG2K'(K - 1));
      col_end   = (col == COL_W'(IMG_W - 1));
      row_end   = (row == ROW_W'(IMG_H - 1));
      idx       = IDX_W'(col >> LOG2K);
      px        = ACC_W'(in_data);
      h_next    = (grp_pos == '0) ? px : combine(mode_eff, h_acc, px);
      buf_rd    = row_buf[idx];
      win_res   = combine(mode_eff, buf_rd, h_next);
      res_fmt   = win_res[DATA_W-1:0];
`ifdef POOL_AVG_EN
      if (!mode_eff) res_fmt = DATA_W'(win_res >> (2 * LOG2K));
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col       <= '0;
         row       <= '0;
         mode_q    <= 1'b0;
         h_acc     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         if (drain) out_valid <= 1'b0;
         if (accept) begin
            if (first_pix) mode_q <= mode;
            h_acc <= h_next;
            if (col_end) begin
               col <= '0;
               row <= row_end ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
            // A completing pixel replaces any result draining this same cycle.
            if (win_end) begin
               out_valid <= 1'b1;
               out_data  <= res_fmt;
               out_last  <= row_end && col_end;
            end
         end
      end
   end

   // Partial column results for the current band of K rows; never read before written.
   always_ff @(posedge clk) begin
      if (accept && grp_end && !win_end)
         row_buf[idx] <= (row_pos == '0) ? h_next : combine(mode_eff, buf_rd, h_next);
   end

endmodule

// File: tb/tb_pool2d_stream.sv
// Self-checking bench for pool2d_stream on a 4x4 image with K=2: directed cases plus
// randomized frames, compared against a window-level reference model via a scoreboard.
module tb_pool2d_stream;
   localparam int DW = 16;
   localparam int IW = 4;
   localparam int IH = 4;
   localparam int K  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ce = 1'b1, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, out_valid, out_last;
   logic [DW-1:0] out_data;

   always #5 clk = ~clk;

   pool2d_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(K)) dut (
      .clk(clk), .rst(rst), .ce(ce), .mode(mode),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ready(out_ready)
   );

   logic [DW:0] exp_q[$];
   int n_vec = 0, n_err = 0;
   int pos = 0;
   bit m_q = 1'b0;
   int img [IH][IW];
   bit win_done = 1'b0;
   bit rand_mode = 1'b0;
   bit stall_pending = 1'b0;
   int stall_cnt = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: a window's result straight from the stored image pixels.
   function automatic logic [DW-1:0] win_result(input int wr, input int wc, input bit m);
      longint s = 0, mx = 0, v;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++) begin
            v = img[wr*K+i][wc*K+j];
            s += v;
            if (v > mx) mx = v;
         end
      if (m) return DW'(mx);
`ifdef POOL_AVG_EN
      return DW'(s / (K * K));
`else
      return DW'(s % (longint'(1) << DW));
`endif
   endfunction

   // Background control of ce / out_ready: random phase or a timed output stall.
   always @(posedge clk) begin
      #2;
      if (stall_cnt > 0) begin
         stall_cnt--;
         if (stall_cnt == 0) out_ready = 1'b1;
      end else if (rand_mode) begin
         ce        = ($urandom_range(0, 4) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
      end
   end

   // Monitor: latency, hold-while-stalled and in-order result checks.
   always @(negedge clk) begin
      if (!rst) begin
         if (win_done) begin
            check("latency_out_valid", out_valid, 1);
            win_done = 1'b0;
         end
         if (out_valid && !out_ready) begin
            check("stall_in_ready", in_ready, 0);
            if (exp_q.size() != 0) check("stall_hold", {out_last, out_data}, exp_q[0]);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got 0x%0h expected none at %0t",
                        {out_last, out_data}, $time);
            end else begin
               check("result", {out_last, out_data}, exp_q.pop_front());
            end
         end
      end
   end

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      pos = 0;
      win_done = 1'b0;
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_last", out_last, 0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send_pixel(input logic [DW-1:0] d, input bit m);
      int r, c, waitc;
      bit ok;
      waitc = 0;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      mode     = m;
      while (!ok && waitc < 200) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else waitc++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         check("in_ready_timeout", 0, 1);
         return;
      end
      r = pos / IW;
      c = pos % IW;
      if (pos == 0) m_q = m;
      img[r][c] = d;
      if ((r % K == K - 1) && (c % K == K - 1)) begin
         exp_q.push_back({(r == IH - 1 && c == IW - 1), win_result(r / K, c / K, m_q)});
         win_done = 1'b1;
         if (stall_pending) begin
            out_ready = 1'b0;
            stall_cnt = 5;
            stall_pending = 1'b0;
         end
      end
      pos = (pos + 1) % (IW * IH);
   endtask

   task automatic ce_pause();
      ce = 1'b0;
      in_valid = 1'b1;
      in_data = 16'hBEEF;
      repeat (3) begin
         @(negedge clk);
         check("ce_low_in_ready", in_ready, 0);
         @(posedge clk);
         #1;
      end
      ce = 1'b1;
      in_valid = 1'b0;
   endtask

   // pat: 0 = ramp 0..15, 1 = all 0xFFFF, else random
   task automatic send_frame(input int pat, input bit m, input int toggle_at, input int ce_at,
                             input int stop_at, input bit gaps);
      logic [DW-1:0] d;
      for (int p = 0; p < IW * IH; p++) begin
         if (p == stop_at) break;
         if (p == ce_at) ce_pause();
         case (pat)
            0:       d = DW'(p);
            1:       d = 16'hFFFF;
            default: d = DW'($urandom_range(0, 65535));
         endcase
         send_pixel(d, (toggle_at >= 0 && p >= toggle_at) ? ~m : m);
         if (gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      do_reset();
      send_frame(0, 1'b1, -1, -1, -1, 1'b0);   // max: 5, 7, 13, 15
      send_frame(0, 1'b0, -1, -1, -1, 1'b0);   // sum / average
      send_frame(1, 1'b0, -1, -1, -1, 1'b0);   // saturating-width sum case
      stall_pending = 1'b1;
      send_frame(0, 1'b1, -1, -1, -1, 1'b0);   // output stall after first result
      send_frame(0, 1'b1, 4, -1, -1, 1'b0);    // mode toggles mid-frame, stays max
      send_frame(0, 1'b0, -1, -1, -1, 1'b0);   // next frame picks up sum
      send_frame(0, 1'b1, -1, -1, 7, 1'b0);    // partial frame, then reset
      do_reset();
      send_frame(0, 1'b1, -1, -1, -1, 1'b0);
      send_frame(2, 1'b0, -1, 6, -1, 1'b0);    // ce low mid-frame
      rand_mode = 1'b1;
      for (int f = 0; f < 10; f++)
         send_frame(2, bit'($urandom_range(0, 1)), -1, -1, -1, 1'b1);
      rand_mode = 1'b0;
      @(posedge clk);
      #3;
      ce = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      check("drained_queue_size", exp_q.size(), 0);
      check("final_out_valid", out_valid, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pool2d_stream.md
Name: pool2d_stream

Overview:
- Streaming 2-D pooling engine. Successor to the combinational two-input max/sum comparator; stays a single-cycle comparator-per-pixel design.
- Consumes one feature-map channel as a raster pixel stream. Produces one pooled result per non-overlapping KxK window.
- Sits between a convolution output and the next layer's input buffer. Uses valid/ready on both sides.
- Runtime mode select: max or sum/average.

Parameters:
- DATA_W, 16, pixel width; unsigned.
- IMG_W, 28, feature-map width in pixels; must be a multiple of K.
- IMG_H, 28, feature-map height in pixels; must be a multiple of K.
- K, 2, window size and stride; legal values are 2 and 4. Elaboration error otherwise, or if IMG_W or IMG_H is not a multiple of K.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  enable; when low, no pixel is accepted and no state changes. A pending output still drains.
- mode  in  1  0 = sum/average, 1 = max. Sampled on the first pixel of a frame.
- in_valid  in  1  input pixel valid.
- in_data  in  DATA_W  input pixel.
- in_ready  out  1  engine can accept a pixel.
- out_valid  out  1  pooled result valid.
- out_data  out  DATA_W  pooled result.
- out_last  out  1  marks the final result of a frame; qualified by out_valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Accept rule: a pixel is accepted when in_valid && in_ready.
- in_ready = ce && (!out_valid || out_ready). Combinational; the output register is 1 deep.
- Counters:
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1, advancing only on accept.
  - col wraps to 0 after IMG_W-1 and row then increments.
  - After (IMG_H-1, IMG_W-1), both wrap to 0 and a new frame begins.
- ACC_W = DATA_W + 2*log2(K). Sums never overflow internally.
- Horizontal stage: a register combines K consecutive pixels of a row. Max keeps the larger operand; sum adds. The first pixel of a group loads directly.
- Row buffer:
  - IMG_W/K entries of ACC_W bits, indexed by col/K.
  - On the last pixel of a horizontal group (col%K == K-1), the combined group result goes to the buffer:
    - row%K == 0: buffer entry is loaded.
    - 0 < row%K < K-1: combined into the entry.
    - row%K == K-1: combined with the entry and sent to the output register instead of the buffer.
- Output register:
  - out_valid rises on the clock edge that accepts the completing pixel, so latency is 1 cycle after the last window pixel is accepted.
  - out_valid is held until out_valid && out_ready.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - Accept and drain may occur in the same cycle; the new result replaces the old one with no bubble.
- Result formatting:
  - Max: the low DATA_W bits, which are exact.
  - Sum: see Optional Feature.
- mode_q is latched on the accept of the pixel at (0,0). A mode change mid-frame has no effect until the next frame.
- out_last = 1 for the result whose window ends at (IMG_H-1, IMG_W-1).
- Reset values: out_valid=0, out_data=0, out_last=0, counters=0, mode_q=0, horizontal register=0. Row-buffer contents are don't-care; every entry is written before it is read.
- Reset mid-frame discards partial windows and any pending output. The next accepted pixel is treated as (0,0).
- ce low mid-frame freezes counters and partial sums. Resuming continues the same frame.

Optional Feature:
- Macro POOL_AVG_EN.
- Defined: in mode 0, out_data = sum >> (2*log2(K)), i.e. the truncating average; it always fits DATA_W.
- Undefined: in mode 0, out_data = sum[DATA_W-1:0]. This is a wrapping sum, matching the legacy sum behaviour.
- Max mode is identical in both builds.

Test Plan:
- IMG 4x4, K=2, mode=1, pixels 0..15 raster, out_ready=1 → outputs 5, 7, 13, 15; out_last only on 15; each output 1 cycle after pixels 5, 7, 13, 15 are accepted.
- Same stream, mode=0:
  - POOL_AVG_EN undefined → 10, 18, 42, 50.
  - POOL_AVG_EN defined → 2, 4, 10, 12.
- Mode=0, DATA_W=16, all pixels 0xFFFF, without macro → 0xFFFC per window. With macro → 0xFFFF.
- Mode=1, out_ready held low for 5 cycles after the first result → out_valid=1 and out_data=5 stable throughout; in_ready=0; no pixel lost; then 7, 13, 15 follow.
- Toggle mode to 0 after pixel 3 of a mode=1 frame → whole frame stays max (5, 7, 13, 15); the next frame uses sum.
- Assert rst after pixel 6, then send pixels 0..15 → exactly 4 correct outputs; none derived from pre-reset data. ce low for 3 cycles mid-frame → in_ready=0 and results unchanged.
